// File: rtl/tx_framer_if.sv
// tx_framer_if: SPI byte input handshake plus RF frame line and status of tx_framer.
interface tx_framer_if #(parameter int FIFO_DEPTH = 16);
   logic [7:0] din;
   logic din_vld, din_rdy, tx_out, tx_busy, bit_stb, done, ovf;
   logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
   modport master (output din, din_vld, input din_rdy, tx_out, tx_busy, bit_stb, done, ovf, fifo_cnt);
   modport slave (input din, din_vld, output din_rdy, tx_out, tx_busy, bit_stb, done, ovf, fifo_cnt);
endinterface

// File: rtl/tx_framer.sv
// tx_framer: byte FIFO feeding a serial RF framer (preamble, sync, payload, CRC-8, idle gap).
module tx_framer #(
   parameter int BIT_DIV = 16,
   parameter int PREAMBLE_BYTES = 2,
   parameter logic [7:0] SYNC_WORD = 8'hD3,
   parameter int PKT_BYTES = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int GAP_BITS = 8
) (
   input logic clk,
   input logic rst,
   tx_framer_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(BIT_DIV);
   typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, PAYLOAD, CRC, GAP} state_t;
   state_t state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [2:0] bit_q, bit_d;
   logic [15:0] bc_q, bc_d;
   logic [7:0] sh_q, sh_d, crc_q, crc_d, nb;
   logic tx_q, tx_d, done_q, done_d, ovf_q, ovf_d, ld;
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0] mem [FIFO_DEPTH];
   logic push, pop, stb, adv;
   assign bus.din_rdy = cnt_q != CW'(FIFO_DEPTH);
   assign push = bus.din_vld && bus.din_rdy;
   assign stb = state_q != IDLE && div_q == '0;
   assign adv = state_q != IDLE && div_q == DW'(BIT_DIV - 1);
   // each payload byte leaves the FIFO on the strobe of its first bit
   assign pop = state_q == PAYLOAD && stb && bit_q == 3'd7;
   always_comb begin
      ovf_d = ovf_q | (bus.din_vld & ~bus.din_rdy);
      wr_d = push ? wr_q + 1'b1 : wr_q;
      rd_d = pop ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      div_d = (state_q == IDLE || adv) ? '0 : div_q + 1'b1;
      crc_d = (state_q == PAYLOAD && stb) ? ({crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ tx_q) ? 8'h07 : 8'h00)) : crc_q;
      state_d = state_q;
      bit_d = bit_q;
      bc_d = bc_q;
      sh_d = sh_q;
      tx_d = tx_q;
      done_d = 1'b0;
      ld = 1'b0;
      nb = mem[rd_q];
      if (state_q == IDLE) begin
         if (cnt_q >= CW'(PKT_BYTES)) begin
            state_d = PREAMBLE;
            bc_d = '0;
            crc_d = '0;
            ld = 1'b1;
            nb = 8'hAA;
         end
      end else if (adv && state_q != GAP && bit_q != 3'd0) begin
         bit_d = bit_q - 3'd1;
         tx_d = sh_q[bit_q - 3'd1];
      end else if (adv) begin
         ld = 1'b1;
         unique case (state_q)
            PREAMBLE: if (bc_q == 16'(PREAMBLE_BYTES - 1)) begin state_d = SYNC; nb = SYNC_WORD; end
                      else begin bc_d = bc_q + 16'd1; nb = 8'hAA; end
            SYNC: begin state_d = PAYLOAD; bc_d = '0; end
            PAYLOAD: if (bc_q == 16'(PKT_BYTES - 1)) begin state_d = CRC; nb = crc_q; end
                     else bc_d = bc_q + 16'd1;
            CRC: begin state_d = GAP; bc_d = '0; ld = 1'b0; tx_d = 1'b0; end
            default: begin
               ld = 1'b0;
               if (bc_q == 16'(GAP_BITS - 1)) begin state_d = IDLE; done_d = 1'b1; end
               else bc_d = bc_q + 16'd1;
            end
         endcase
      end
      if (ld) begin
         sh_d = nb;
         tx_d = nb[7];
         bit_d = 3'd7;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         div_q <= '0;
         bit_q <= '0;
         bc_q <= '0;
         sh_q <= '0;
         crc_q <= '0;
         tx_q <= 1'b0;
         done_q <= 1'b0;
         ovf_q <= 1'b0;
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         div_q <= div_d;
         bit_q <= bit_d;
         bc_q <= bc_d;
         sh_q <= sh_d;
         crc_q <= crc_d;
         tx_q <= tx_d;
         done_q <= done_d;
         ovf_q <= ovf_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= bus.din;
   end
   assign bus.tx_out = tx_q;
   assign bus.tx_busy = state_q != IDLE;
   assign bus.bit_stb = stb;
   assign bus.done = done_q;
   assign bus.ovf = ovf_q;
   assign bus.fifo_cnt = cnt_q;
endmodule
